// File: rtl/ibex_pkg.sv
// Shared LSU types and helpers.
// Provides the access-size and FSM-state enums plus small pure functions used
// by ibex_lsu_sync (size normalisation, split detection, byte-lane masks and
// store-data rotation).
package ibex_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    LSU_WORD = 2'b00,
    LSU_HALF = 2'b01,
    LSU_BYTE = 2'b10
  } lsu_type_e;

  typedef enum logic [2:0] {
    LSU_IDLE,
    LSU_REQ1,
    LSU_WAIT1,
    LSU_REQ2,
    LSU_WAIT2
  } lsu_state_e;

  // The unused encoding 2'b11 behaves as a word access.
  function automatic lsu_type_e norm_type(input logic [1:0] t);
    if (t == 2'b11) return LSU_WORD;
    return lsu_type_e'(t);
  endfunction

  function automatic logic [3:0] base_mask(input lsu_type_e t);
    case (t)
      LSU_HALF: return 4'b0011;
      LSU_BYTE: return 4'b0001;
      default:  return 4'b1111;
    endcase
  endfunction

  // An access splits when its bytes cross a word boundary.
  function automatic logic needs_split(input lsu_type_e t, input logic [1:0] off);
    return ((t == LSU_WORD) && (off != 2'd0)) || ((t == LSU_HALF) && (off == 2'd3));
  endfunction

  // Byte enables for the first (low word) or second (high word) phase.
  function automatic logic [3:0] phase_be(input lsu_type_e t, input logic [1:0] off,
                                          input logic second);
    logic [7:0] m;
    m = 8'({4'b0000, base_mask(t)} << off);
    return second ? 4'(m >> 4) : 4'(m);
  endfunction

  // Rotate store data left by whole bytes so byte 0 lands on lane 'off'.
  function automatic logic [DATA_W-1:0] rotl_bytes(input logic [DATA_W-1:0] d,
                                                   input logic [1:0] off);
    case (off)
      2'd1:    return {d[23:0], d[31:24]};
      2'd2:    return {d[15:0], d[31:16]};
      2'd3:    return {d[7:0],  d[31:8]};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/ibex_lsu_rdata_align.sv
// Load-data alignment and extension (purely combinational).
// Ports:
//   data     - merged {high word, low word} read data
//   offset   - byte offset of the access within the low word
//   lsu_type - access size
//   sign_ext - 1 = sign-extend, 0 = zero-extend
//   result   - LSB-justified, extended load value
module ibex_lsu_rdata_align
  import ibex_pkg::*;
(
  input  logic [63:0] data,
  input  logic [1:0]  offset,
  input  lsu_type_e   lsu_type,
  input  logic        sign_ext,
  output logic [31:0] result
);

  logic [31:0] shifted;

  assign shifted = 32'(data >> {offset, 3'b000});

  always_comb begin
    result = shifted;
    case (lsu_type)
      LSU_HALF: result = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      LSU_BYTE: result = {{24{sign_ext & shifted[7]}},  shifted[7:0]};
      default:  result = shifted;
    endcase
  end

endmodule

// File: rtl/ibex_lsu_sync.sv
// Load/store unit between EX and the data-memory req/gnt/rvalid bus.
// Accepts one access at a time, splits misaligned accesses into two
// word-aligned bus transactions and returns aligned, extended load data.
// Ports:
//   clk_i, rst_i                   - clock, synchronous active-high reset
//   lsu_req_i .. adder_result_ex_i - request from ID/EX
//   data_*                         - data-memory bus
//   lsu_busy_o                     - unit is not idle
//   lsu_resp_valid_o/rdata_o/err_o - registered one-cycle completion
module ibex_lsu_sync
  import ibex_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_type_i,
  input  logic        lsu_sign_ext_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [31:0] adder_result_ex_i,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  input  logic [31:0] data_rdata_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  output logic        lsu_busy_o,
  output logic        lsu_resp_valid_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_err_o
);

  lsu_state_e  state;
  lsu_type_e   type_q;
  logic        sign_q;
  logic [1:0]  off_q;
  logic        split_q;
  logic [31:0] rdata_lo_q;

  logic        accept;
  lsu_type_e   req_type;
  logic [63:0] merged;
  logic [31:0] aligned;

  assign accept   = lsu_req_i & ~lsu_busy_o;
  assign req_type = norm_type(lsu_type_i);

  // Second-phase data sits above the buffered first word; single-phase loads see zeros above.
  assign merged = (state == LSU_WAIT2) ? {data_rdata_i, rdata_lo_q} : {32'h0, data_rdata_i};

  ibex_lsu_rdata_align u_align (
    .data     (merged),
    .offset   (off_q),
    .lsu_type (type_q),
    .sign_ext (sign_q),
    .result   (aligned)
  );

  // FSM with registered bus and response outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= LSU_IDLE;
      type_q           <= LSU_WORD;
      sign_q           <= 1'b0;
      off_q            <= 2'd0;
      split_q          <= 1'b0;
      rdata_lo_q       <= 32'h0;
      data_req_o       <= 1'b0;
      data_addr_o      <= 32'h0;
      data_we_o        <= 1'b0;
      data_be_o        <= 4'h0;
      data_wdata_o     <= 32'h0;
      lsu_busy_o       <= 1'b0;
      lsu_resp_valid_o <= 1'b0;
      lsu_rdata_o      <= 32'h0;
      lsu_err_o        <= 1'b0;
    end else begin
      lsu_resp_valid_o <= 1'b0;
      lsu_err_o        <= 1'b0;
      case (state)
        LSU_IDLE: begin
          if (accept) begin
            state        <= LSU_REQ1;
            lsu_busy_o   <= 1'b1;
            type_q       <= req_type;
            sign_q       <= lsu_sign_ext_i;
            off_q        <= adder_result_ex_i[1:0];
            split_q      <= needs_split(req_type, adder_result_ex_i[1:0]);
            data_req_o   <= 1'b1;
            data_addr_o  <= {adder_result_ex_i[31:2], 2'b00};
            data_we_o    <= lsu_we_i;
            data_be_o    <= phase_be(req_type, adder_result_ex_i[1:0], 1'b0);
            data_wdata_o <= rotl_bytes(lsu_wdata_i, adder_result_ex_i[1:0]);
          end
        end
        LSU_REQ1: begin
          if (data_gnt_i) begin
            state      <= LSU_WAIT1;
            data_req_o <= 1'b0;
          end
        end
        LSU_WAIT1: begin
          if (data_rvalid_i) begin
            if (!data_err_i && split_q) begin
              state       <= LSU_REQ2;
              rdata_lo_q  <= data_rdata_i;
              data_req_o  <= 1'b1;
              data_addr_o <= data_addr_o + 32'd4;
              data_be_o   <= phase_be(type_q, off_q, 1'b1);
            end else begin
              state            <= LSU_IDLE;
              lsu_busy_o       <= 1'b0;
              lsu_resp_valid_o <= 1'b1;
              lsu_err_o        <= data_err_i;
              lsu_rdata_o      <= data_we_o ? 32'h0 : aligned;
            end
          end
        end
        LSU_REQ2: begin
          if (data_gnt_i) begin
            state      <= LSU_WAIT2;
            data_req_o <= 1'b0;
          end
        end
        LSU_WAIT2: begin
          if (data_rvalid_i) begin
            state            <= LSU_IDLE;
            lsu_busy_o       <= 1'b0;
            lsu_resp_valid_o <= 1'b1;
            lsu_err_o        <= data_err_i;
            lsu_rdata_o      <= data_we_o ? 32'h0 : aligned;
          end
        end
        default: begin
          state      <= LSU_IDLE;
          lsu_busy_o <= 1'b0;
          data_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_lsu_sync.sv
// Directed self-checking bench for ibex_lsu_sync with a bus responder and
// scoreboard queues for expected bus transactions and responses.
module tb_ibex_lsu_sync;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [1:0]  lsu_type_i;
  logic        lsu_sign_ext_i;
  logic [31:0] lsu_wdata_i;
  logic [31:0] adder_result_ex_i;
  logic        data_req_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic        data_err_i;
  logic [31:0] data_rdata_i;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        lsu_busy_o;
  logic        lsu_resp_valid_o;
  logic [31:0] lsu_rdata_o;
  logic        lsu_err_o;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk_rdata;
    int          cyc;
  } resp_t;

  bus_t  exp_bus[$];
  resp_t exp_resp[$];

  ibex_lsu_sync dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .lsu_req_i         (lsu_req_i),
    .lsu_we_i          (lsu_we_i),
    .lsu_type_i        (lsu_type_i),
    .lsu_sign_ext_i    (lsu_sign_ext_i),
    .lsu_wdata_i       (lsu_wdata_i),
    .adder_result_ex_i (adder_result_ex_i),
    .data_req_o        (data_req_o),
    .data_gnt_i        (data_gnt_i),
    .data_rvalid_i     (data_rvalid_i),
    .data_err_i        (data_err_i),
    .data_rdata_i      (data_rdata_i),
    .data_addr_o       (data_addr_o),
    .data_we_o         (data_we_o),
    .data_be_o         (data_be_o),
    .data_wdata_o      (data_wdata_o),
    .lsu_busy_o        (lsu_busy_o),
    .lsu_resp_valid_o  (lsu_resp_valid_o),
    .lsu_rdata_o       (lsu_rdata_o),
    .lsu_err_o         (lsu_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bus(input logic [31:0] a, input logic [3:0] be, input logic we,
                          input logic [31:0] wd);
    bus_t b;
    b.addr = a; b.be = be; b.we = we; b.wdata = wd;
    exp_bus.push_back(b);
  endtask

  // Issue one request and act as the memory until the response appears.
  task automatic run_access(input logic [31:0] a, input logic we, input logic [1:0] typ,
                            input logic sx, input logic [31:0] wd,
                            input logic [31:0] rd1, input logic [31:0] rd2,
                            input logic err1, input int gdelay,
                            input logic [31:0] exp_rdata, input logic exp_err,
                            input logic chk_rdata, input int exp_cyc);
    resp_t r;
    resp_t got;
    bus_t  cur;
    int    cyc;
    int    stall;
    int    phase;
    logic  seen;
    logic  pending;
    logic  done;
    r.rdata = exp_rdata; r.err = exp_err; r.chk_rdata = chk_rdata; r.cyc = exp_cyc;
    exp_resp.push_back(r);
    cur = '{addr: 32'h0, be: 4'h0, we: 1'b0, wdata: 32'h0};
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_type_i = typ; lsu_sign_ext_i = sx;
    lsu_wdata_i = wd; adder_result_ex_i = a;
    next_cycle();
    lsu_req_i = 1'b0;
    cyc = 1; stall = 0; phase = 0; seen = 1'b0; pending = 1'b0; done = 1'b0;
    while (!done && cyc < 40) begin
      data_rvalid_i = pending;
      data_err_i    = pending && phase == 0 && err1;
      data_rdata_i  = (phase == 0) ? rd1 : rd2;
      if (pending) phase++;
      pending    = 1'b0;
      data_gnt_i = 1'b0;
      if (lsu_resp_valid_o) begin
        got = exp_resp.pop_front();
        check("resp_cycle", 32'(cyc), 32'(got.cyc));
        check("resp_err", {31'h0, lsu_err_o}, {31'h0, got.err});
        if (got.chk_rdata) check("resp_rdata", lsu_rdata_o, got.rdata);
        done = 1'b1;
      end else if (data_req_o) begin
        if (!seen) begin
          if (exp_bus.size() == 0) begin
            check("extra_req", data_addr_o, 32'hxxxx_xxxx);
          end else begin
            cur = exp_bus.pop_front();
            check("bus_addr", data_addr_o, cur.addr);
            check("bus_be", {28'h0, data_be_o}, {28'h0, cur.be});
            check("bus_we", {31'h0, data_we_o}, {31'h0, cur.we});
            check("bus_wdata", data_wdata_o, cur.wdata);
          end
          seen = 1'b1;
          stall = 0;
        end else begin
          check("stall_addr", data_addr_o, cur.addr);
          check("stall_be", {28'h0, data_be_o}, {28'h0, cur.be});
        end
        if (stall >= gdelay) begin
          data_gnt_i = 1'b1;
          pending = 1'b1;
          seen = 1'b0;
        end else begin
          stall++;
        end
      end
      if (!done) begin
        next_cycle();
        cyc++;
      end
    end
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
    if (!done) begin
      check("resp_timeout", 32'(cyc), 32'd0);
      exp_resp.delete();
    end
    check("bus_left", 32'(exp_bus.size()), 32'd0);
    exp_bus.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   {31'h0, data_req_o}, 32'h0);
    check({tag, "_addr"},  data_addr_o, 32'h0);
    check({tag, "_we"},    {31'h0, data_we_o}, 32'h0);
    check({tag, "_be"},    {28'h0, data_be_o}, 32'h0);
    check({tag, "_wdata"}, data_wdata_o, 32'h0);
    check({tag, "_busy"},  {31'h0, lsu_busy_o}, 32'h0);
    check({tag, "_rv"},    {31'h0, lsu_resp_valid_o}, 32'h0);
    check({tag, "_rdata"}, lsu_rdata_o, 32'h0);
    check({tag, "_err"},   {31'h0, lsu_err_o}, 32'h0);
  endtask

  initial begin
    rst_i = 1'b1; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_type_i = 2'b00;
    lsu_sign_ext_i = 1'b0; lsu_wdata_i = 32'h0; adder_result_ex_i = 32'h0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = 32'h0;
    next_cycle();
    next_cycle();
    rst_i = 1'b0;
    check_reset_outputs("reset");

    // Aligned word load, zero-wait memory.
    push_bus(32'h0000_1000, 4'b1111, 1'b0, 32'h0);
    run_access(32'h0000_1000, 1'b0, 2'b00, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b0, 0,
               32'hDEAD_BEEF, 1'b0, 1'b1, 3);
    next_cycle();

    // Half loads at offset 2, signed then unsigned.
    push_bus(32'h0000_2000, 4'b1100, 1'b0, 32'h0);
    run_access(32'h0000_2002, 1'b0, 2'b01, 1'b1, 32'h0, 32'h8001_0000, 32'h0, 1'b0, 0,
               32'hFFFF_8001, 1'b0, 1'b1, 3);
    next_cycle();
    push_bus(32'h0000_2000, 4'b1100, 1'b0, 32'h0);
    run_access(32'h0000_2002, 1'b0, 2'b01, 1'b0, 32'h0, 32'h8001_0000, 32'h0, 1'b0, 0,
               32'h0000_8001, 1'b0, 1'b1, 3);
    next_cycle();

    // Misaligned word store split across two words.
    push_bus(32'h0000_3000, 4'b1110, 1'b1, 32'h2233_4411);
    push_bus(32'h0000_3004, 4'b0001, 1'b1, 32'h2233_4411);
    run_access(32'h0000_3001, 1'b1, 2'b00, 1'b0, 32'h1122_3344, 32'h0, 32'h0, 1'b0, 0,
               32'h0, 1'b0, 1'b1, 5);
    next_cycle();

    // Misaligned word load wrapping the top of the address space.
    push_bus(32'hFFFF_FFFC, 4'b1000, 1'b0, 32'h0);
    push_bus(32'h0000_0000, 4'b0111, 1'b0, 32'h0);
    run_access(32'hFFFF_FFFF, 1'b0, 2'b00, 1'b0, 32'h0, 32'hAA00_0000, 32'h00BB_CCDD,
               1'b0, 0, 32'hBBCC_DDAA, 1'b0, 1'b1, 5);
    next_cycle();

    // Split half load, grant withheld 3 cycles, phase-1 error aborts phase 2.
    push_bus(32'h0000_4000, 4'b1000, 1'b0, 32'h0);
    run_access(32'h0000_4003, 1'b0, 2'b01, 1'b0, 32'h0, 32'h1234_5678, 32'h9ABC_DEF0,
               1'b1, 3, 32'h0, 1'b1, 1'b0, 6);
    for (int i = 0; i < 3; i++) begin
      check("no_phase2_req", {31'h0, data_req_o}, 32'h0);
      check("err_idle_busy", {31'h0, lsu_busy_o}, 32'h0);
      next_cycle();
    end

    // Reset while waiting for rvalid; the late rvalid must be ignored.
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_type_i = 2'b00; lsu_sign_ext_i = 1'b0;
    lsu_wdata_i = 32'hCAFE_F00D; adder_result_ex_i = 32'h0000_5000;
    next_cycle();
    lsu_req_i = 1'b0;
    data_gnt_i = 1'b1;
    next_cycle();
    data_gnt_i = 1'b0;
    check("rst_in_wait1_busy", {31'h0, lsu_busy_o}, 32'h1);
    rst_i = 1'b1;
    next_cycle();
    rst_i = 1'b0;
    data_rvalid_i = 1'b1; data_rdata_i = 32'h5555_5555;
    check_reset_outputs("rst_wait1");
    next_cycle();
    data_rvalid_i = 1'b0;
    check("rst_late_rvalid_rv", {31'h0, lsu_resp_valid_o}, 32'h0);
    check("rst_late_rvalid_busy", {31'h0, lsu_busy_o}, 32'h0);

    // Signed byte load followed back-to-back in its response cycle.
    push_bus(32'h0000_6000, 4'b0010, 1'b0, 32'h0);
    run_access(32'h0000_6001, 1'b0, 2'b10, 1'b1, 32'h0, 32'h0000_8000, 32'h0, 1'b0, 0,
               32'hFFFF_FF80, 1'b0, 1'b1, 3);
    push_bus(32'h0000_6000, 4'b1000, 1'b0, 32'h0);
    run_access(32'h0000_6003, 1'b0, 2'b10, 1'b0, 32'h0, 32'h7F00_0000, 32'h0, 1'b0, 0,
               32'h0000_007F, 1'b0, 1'b1, 3);
    next_cycle();
    check("final_err_low", {31'h0, lsu_err_o}, 32'h0);
    check("final_rdata_hold", lsu_rdata_o, 32'h0000_007F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ibex_lsu_sync.md
Name: ibex_lsu_sync

Overview:
- Load/store unit directly downstream of the execution block.
- Consumes the ALU adder result as the effective address and the store operand from ID.
- Drives the data-memory req/gnt/rvalid bus and returns aligned, sign/zero-extended load data for register writeback.
- Splits misaligned accesses into two word-aligned bus transactions and merges the results.

Parameters:
- None. Address and data widths are fixed at 32.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
lsu_req_i  in  1  request valid from ID
lsu_we_i  in  1  1 = store, 0 = load
lsu_type_i  in  2  lsu_type_e: 00 word, 01 half, 10 byte (11 treated as word)
lsu_sign_ext_i  in  1  sign-extend load data
lsu_wdata_i  in  32  store data, LSB-justified
adder_result_ex_i  in  32  effective address from EX
data_req_o  out  1  bus request
data_gnt_i  in  1  bus grant
data_rvalid_i  in  1  response valid
data_err_i  in  1  bus error, qualified by rvalid
data_rdata_i  in  32  read data, qualified by rvalid
data_addr_o  out  32  word-aligned address (addr[1:0]=00)
data_we_o  out  1  write enable
data_be_o  out  4  byte enables
data_wdata_o  out  32  store data rotated to byte lanes
lsu_busy_o  out  1  state != IDLE
lsu_resp_valid_o  out  1  one-cycle completion pulse (loads and stores)
lsu_rdata_o  out  32  extended load data; 0 for stores
lsu_err_o  out  1  error flag, qualified by resp_valid

Behaviour:
- Reset: synchronous on rst_i. All outputs 0 and state IDLE after the edge. A pending rvalid after reset is ignored.
- Request acceptance: accept = lsu_req_i & ~lsu_busy_o. On accept, the unit registers:
  - address
  - we, type, sign_ext
  - offset = addr[1:0]
  - split flag
- Split rule: split = (word & offset != 0) | (half & offset == 3). Byte accesses never split.
- FSM states: IDLE, REQ1, WAIT1, REQ2, WAIT2.
- IDLE: on accept -> REQ1.
- REQ1:
  - data_req_o = 1, data_addr_o = {addr[31:2], 00}.
  - On gnt -> WAIT1.
  - All bus outputs stay stable until gnt is seen.
- WAIT1: on rvalid:
  - err -> IDLE, error response; second phase skipped.
  - else split -> REQ2, storing rdata in the low-half buffer.
  - else -> IDLE, final response.
- REQ2:
  - data_addr_o = {addr[31:2], 00} + 4, mod 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
  - On gnt -> WAIT2.
- WAIT2: on rvalid -> IDLE, final response; err as received.
- Bus ordering: rvalid arrives at least one cycle after its gnt. rvalid in IDLE/REQx is ignored. data_req_o is 0 in WAITx.
- Byte enables: base mask word 1111, half 0011, byte 0001.
  - Phase 1: data_be_o = (mask << offset)[3:0].
  - Phase 2: data_be_o = (mask << offset)[7:4].
- Write data: data_wdata_o = wdata rotated left by 8*offset, identical in both phases. data_we_o is valid in both phases.
- Load merge: {rdata2, rdata1} >> 8*offset. Non-split loads use {0, rdata1}.
- Load extraction: take bits [31:0] for word, [15:0] for half, [7:0] for byte, then sign- or zero-extend to 32 bits.
- Response timing:
  - lsu_resp_valid_o, lsu_rdata_o and lsu_err_o are registered and asserted in the cycle after the final rvalid.
  - lsu_busy_o is 0 in that cycle, so a new request may be accepted in the same cycle as resp_valid.
- Latency: accept at cycle 0, req at cycle 1. Zero-wait memory gives resp at cycle 3 non-split, cycle 5 split.
- Between responses: lsu_rdata_o holds its last value; lsu_err_o is 0 when resp_valid = 0.

Decomposition:
- ibex_pkg gains:
  - lsu_type_e (LSU_WORD = 2'b00, LSU_HALF = 2'b01, LSU_BYTE = 2'b10)
  - lsu_state_e (LSU_IDLE, LSU_REQ1, LSU_WAIT1, LSU_REQ2, LSU_WAIT2)
- One combinational sub-module, ibex_lsu_rdata_align: inputs are the merged 64-bit data, offset, type and sign_ext; output is the 32-bit result.
- The FSM, byte-enable and write-data logic stay in ibex_lsu_sync.

Test Plan:
- Word load, addr 0x1000, zero-wait memory, rdata 0xDEADBEEF -> one req at 0x1000 with be 1111; resp_valid at cycle 3; lsu_rdata_o = 0xDEADBEEF; err = 0.
- Signed half load at 0x2002, rdata 0x8001_0000 -> be 1100; lsu_rdata_o = 0xFFFF8001. The same load unsigned -> 0x00008001.
- Misaligned word store at 0x3001, wdata 0x11223344:
  - Phase 1: addr 0x3000, be 1110, wdata 0x22334411.
  - Phase 2: addr 0x3004, be 0001, same wdata.
  - One resp_valid pulse; lsu_rdata_o = 0.
- Misaligned word load at 0xFFFF_FFFF:
  - Phase 1: addr 0xFFFF_FFFC, rdata 0xAA000000.
  - Phase 2: addr 0x0000_0000, rdata 0x00BBCCDD.
  - Result: lsu_rdata_o = 0xBBCCDDAA.
- Gnt withheld 3 cycles, then phase-1 rvalid with data_err_i = 1 on a split load at 0x4003:
  - req/addr/be stable over the 3 cycles.
  - No phase-2 request issued.
  - resp_valid with lsu_err_o = 1.
- rst_i asserted in WAIT1, then rvalid the next cycle -> after the reset edge, state IDLE and all outputs 0; no resp_valid. A back-to-back request in the resp_valid cycle is accepted.
